// File: rtl/ttt_auto_player.sv
// ttt_auto_player: tic-tac-toe agent that keeps a shadow board, watches
// opponent moves from the game engine and answers with its own move.
//
// Each THINK pass scores one empty cell per cycle:
//   4 = own mark completes a line
//   3 = blocks an opponent line
//   2 = centre
//   1 = corner
//   0 = any other cell
// The highest score wins, and a tie goes to the lowest cell index.
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   start, my_id, i_first   begin a game; agent id; agent moves first
//   obs_valid, obs_x/obs_y  opponent move accepted by the engine
//   stop_game               game over from the engine
//   enable                  one-cycle move strobe
//   data_in_x/data_in_y     agent move (column/row); held between moves
//   player                  {0,my_id} during the strobe, 3 otherwise
//   busy                    high in WAIT_OPP, THINK and ISSUE
//   err                     sticky flag for an illegal observed move
//
// state    | meaning
// IDLE     | after reset, waiting for start
// WAIT_OPP | waiting for the opponent move
// THINK    | 9-cycle scan of cells 0..8
// ISSUE    | strobe the chosen move
// DONE     | game over, waiting for start
module ttt_auto_player (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       my_id,
  input  logic       i_first,
  input  logic       obs_valid,
  input  logic [1:0] obs_x,
  input  logic [1:0] obs_y,
  input  logic       stop_game,
  output logic       enable,
  output logic [1:0] data_in_x,
  output logic [1:0] data_in_y,
  output logic [1:0] player,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_OPP = 3'd1,
    THINK    = 3'd2,
    ISSUE    = 3'd3,
    DONE     = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [8:0][1:0]  board_q, board_d;
  logic [3:0]       idx_q, idx_d;
  logic             best_valid_q, best_valid_d;
  logic [2:0]       best_score_q, best_score_d;
  logic [3:0]       best_idx_q, best_idx_d;
  logic             my_id_q, my_id_d;
  logic             enable_q, enable_d;
  logic [1:0]       x_q, x_d, y_q, y_d;
  logic [1:0]       player_q, player_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic             cur_empty, take, nb_valid, obs_ok;
  logic [2:0]       cur_score, nb_score;
  logic [3:0]       nb_idx, obs_idx;

  // Three cell indices of each of the eight lines, packed {a, b, c}.
  function automatic logic [11:0] line_cells(input int l);
    case (l)
      0:       line_cells = {4'd0, 4'd1, 4'd2};
      1:       line_cells = {4'd3, 4'd4, 4'd5};
      2:       line_cells = {4'd6, 4'd7, 4'd8};
      3:       line_cells = {4'd0, 4'd3, 4'd6};
      4:       line_cells = {4'd1, 4'd4, 4'd7};
      5:       line_cells = {4'd2, 4'd5, 4'd8};
      6:       line_cells = {4'd0, 4'd4, 4'd8};
      default: line_cells = {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  // Score for placing at idx. A line counts only when the other two cells
  // of that line already hold the same mark.
  function automatic logic [2:0] cell_score(input logic [8:0][1:0] b,
                                            input logic [3:0] idx,
                                            input logic me);
    logic [11:0] ln;
    logic [3:0]  p, q;
    logic        hit, win, blk;
    win = 1'b0;
    blk = 1'b0;
    for (int l = 0; l < 8; l++) begin
      ln  = line_cells(l);
      hit = 1'b1;
      p   = ln[7:4];
      q   = ln[3:0];
      if (idx == ln[11:8]) begin
        p = ln[7:4];
        q = ln[3:0];
      end else if (idx == ln[7:4]) begin
        p = ln[11:8];
        q = ln[3:0];
      end else if (idx == ln[3:0]) begin
        p = ln[11:8];
        q = ln[7:4];
      end else begin
        hit = 1'b0;
      end
      if (hit && b[p] == {1'b0, me} && b[q] == {1'b0, me}) win = 1'b1;
      if (hit && b[p] == {1'b0, ~me} && b[q] == {1'b0, ~me}) blk = 1'b1;
    end
    if (win)                                        cell_score = 3'd4;
    else if (blk)                                   cell_score = 3'd3;
    else if (idx == 4'd4)                           cell_score = 3'd2;
    else if (idx == 4'd0 || idx == 4'd2 ||
             idx == 4'd6 || idx == 4'd8)            cell_score = 3'd1;
    else                                            cell_score = 3'd0;
  endfunction

  // Convert a cell index to its column (x) and row (y).
  function automatic logic [3:0] idx_xy(input logic [3:0] idx);
    case (idx)
      4'd0:    idx_xy = {2'd0, 2'd0};
      4'd1:    idx_xy = {2'd1, 2'd0};
      4'd2:    idx_xy = {2'd2, 2'd0};
      4'd3:    idx_xy = {2'd0, 2'd1};
      4'd4:    idx_xy = {2'd1, 2'd1};
      4'd5:    idx_xy = {2'd2, 2'd1};
      4'd6:    idx_xy = {2'd0, 2'd2};
      4'd7:    idx_xy = {2'd1, 2'd2};
      default: idx_xy = {2'd2, 2'd2};
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    board_d      = board_q;
    idx_d        = idx_q;
    best_valid_d = best_valid_q;
    best_score_d = best_score_q;
    best_idx_d   = best_idx_q;
    my_id_d      = my_id_q;
    x_d          = x_q;
    y_d          = y_q;
    err_d        = err_q;

    cur_empty = (board_q[idx_q] == 2'b11);
    cur_score = cell_score(board_q, idx_q, my_id_q);
    // A later cell replaces the running best only on a strictly higher
    // score, so a tie keeps the lower index.
    take      = cur_empty && (!best_valid_q || cur_score > best_score_q);
    nb_valid  = best_valid_q | take;
    nb_idx    = take ? idx_q : best_idx_q;
    nb_score  = take ? cur_score : best_score_q;

    obs_idx   = {2'b00, obs_y} * 4'd3 + {2'b00, obs_x};
    obs_ok    = (obs_x != 2'd3) && (obs_y != 2'd3) && (board_q[obs_idx] == 2'b11);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          board_d      = '1;
          err_d        = 1'b0;
          my_id_d      = my_id;
          idx_d        = 4'd0;
          best_valid_d = 1'b0;
          state_d      = i_first ? THINK : WAIT_OPP;
        end
      end
      WAIT_OPP: begin
        if (stop_game) begin
          state_d = DONE;
        end else if (obs_valid) begin
          if (obs_ok) begin
            board_d[obs_idx] = {1'b0, ~my_id_q};
            idx_d            = 4'd0;
            best_valid_d     = 1'b0;
            state_d          = THINK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      THINK: begin
        if (stop_game) begin
          state_d = DONE;
        end else if (idx_q == 4'd8) begin
          // The last cell is folded in combinationally so the decision
          // lands on the ninth edge.
          if (nb_valid) begin
            board_d[nb_idx] = {1'b0, my_id_q};
            {x_d, y_d}      = idx_xy(nb_idx);
            state_d         = ISSUE;
          end else begin
            state_d = DONE;
          end
        end else begin
          idx_d        = idx_q + 4'd1;
          best_valid_d = nb_valid;
          best_score_d = nb_score;
          best_idx_d   = nb_idx;
        end
      end
      ISSUE: state_d = stop_game ? DONE : WAIT_OPP;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    enable_d = (state_d == ISSUE);
    player_d = (state_d == ISSUE) ? {1'b0, my_id_q} : 2'b11;
    busy_d   = (state_d == WAIT_OPP) || (state_d == THINK) || (state_d == ISSUE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      board_q      <= '1;
      idx_q        <= 4'd0;
      best_valid_q <= 1'b0;
      best_score_q <= 3'd0;
      best_idx_q   <= 4'd0;
      my_id_q      <= 1'b0;
      enable_q     <= 1'b0;
      x_q          <= 2'd0;
      y_q          <= 2'd0;
      player_q     <= 2'b11;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      idx_q        <= idx_d;
      best_valid_q <= best_valid_d;
      best_score_q <= best_score_d;
      best_idx_q   <= best_idx_d;
      my_id_q      <= my_id_d;
      enable_q     <= enable_d;
      x_q          <= x_d;
      y_q          <= y_d;
      player_q     <= player_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign enable    = enable_q;
  assign data_in_x = x_q;
  assign data_in_y = y_q;
  assign player    = player_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ttt_auto_player.sv
// Directed testbench for ttt_auto_player. Inputs change on the falling edge
// and outputs are sampled on the falling edge.
module tb_ttt_auto_player;

  logic       clk = 1'b0;
  logic       reset, start, my_id, i_first, obs_valid, stop_game;
  logic [1:0] obs_x, obs_y;
  logic       enable, busy, err;
  logic [1:0] data_in_x, data_in_y, player;

  int n_vec = 0;
  int n_err = 0;

  ttt_auto_player dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .my_id     (my_id),
    .i_first   (i_first),
    .obs_valid (obs_valid),
    .obs_x     (obs_x),
    .obs_y     (obs_y),
    .stop_game (stop_game),
    .enable    (enable),
    .data_in_x (data_in_x),
    .data_in_y (data_in_y),
    .player    (player),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic id, input logic first);
    start = 1'b1; my_id = id; i_first = first;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_obs(input logic [1:0] x, input logic [1:0] y);
    obs_valid = 1'b1; obs_x = x; obs_y = y;
    @(negedge clk);
    obs_valid = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_game = 1'b1;
    @(negedge clk);
    stop_game = 1'b0;
  endtask

  // Called one falling edge after the accepting edge (n = 1); returns the
  // number of edges until enable is seen, with busy checked on the way.
  task automatic wait_enable(output int n, output bit busy_ok);
    n = 1; busy_ok = 1'b1;
    while (!enable && n < 30) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic expect_move(input string tag, input logic [1:0] ex,
                             input logic [1:0] ey, input logic [1:0] ep);
    int n; bit bok;
    wait_enable(n, bok);
    chk({tag, ".lat"},  n, 10);
    chk({tag, ".en"},   enable, 1'b1);
    chk({tag, ".x"},    data_in_x, ex);
    chk({tag, ".y"},    data_in_y, ey);
    chk({tag, ".pl"},   player, ep);
    chk({tag, ".busy"}, {31'd0, bok}, 1);
    @(negedge clk);
    chk({tag, ".en_off"}, enable, 1'b0);
    chk({tag, ".pl_off"}, player, 2'b11);
  endtask

  initial begin
    int n; bit bok; int ens;
    reset = 1'b1; start = 1'b0; my_id = 1'b0; i_first = 1'b0;
    obs_valid = 1'b0; obs_x = 2'd0; obs_y = 2'd0; stop_game = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.en", enable, 1'b0);
    chk("rst.x", data_in_x, 2'd0);
    chk("rst.y", data_in_y, 2'd0);
    chk("rst.pl", player, 2'b11);
    chk("rst.busy", busy, 1'b0);
    chk("rst.err", err, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Agent id 0 opens: centre
    do_start(1'b0, 1'b1);
    chk("g1.busy", busy, 1'b1);
    expect_move("open", 2'd1, 2'd1, 2'd0);
    // Opponent takes (0,0): first free corner is (2,0)
    do_obs(2'd0, 2'd0);
    expect_move("m2", 2'd2, 2'd0, 2'd0);
    // Opponent (0,1): (0,2) both wins and blocks
    do_obs(2'd0, 2'd1);
    expect_move("win", 2'd0, 2'd2, 2'd0);
    chk("win.err", err, 1'b0);

    // Occupied cell: err, no move, still waiting; outputs hold
    do_obs(2'd1, 2'd1);
    chk("occ.err", err, 1'b1);
    ens = 0;
    repeat (12) begin
      if (enable) ens++;
      @(negedge clk);
    end
    chk("occ.no_en", ens, 0);
    chk("occ.busy", busy, 1'b1);
    chk("occ.hold_x", data_in_x, 2'd0);
    chk("occ.hold_y", data_in_y, 2'd2);
    // Legal follow-up: only corner left is (2,2)
    do_obs(2'd2, 2'd1);
    expect_move("after_err", 2'd2, 2'd2, 2'd0);
    chk("after_err.err", err, 1'b1);

    // start in WAIT_OPP ignored (err would clear otherwise)
    do_start(1'b1, 1'b0);
    chk("ign_start.err", err, 1'b1);
    chk("ign_start.busy", busy, 1'b1);
    pulse_stop();
    chk("stop_wait.busy", busy, 1'b0);

    // Agent id 1 second; out-of-range coordinate, then centre taken
    do_start(1'b1, 1'b0);
    chk("g2.err", err, 1'b0);
    chk("g2.busy", busy, 1'b1);
    chk("g2.en", enable, 1'b0);
    do_obs(2'd3, 2'd0);
    chk("range.err", err, 1'b1);
    do_obs(2'd1, 2'd1);
    expect_move("second", 2'd0, 2'd0, 2'd1);

    // stop_game in THINK cycle 4; obs during THINK ignored
    pulse_stop();
    do_start(1'b0, 1'b1);          // THINK cycle 1 follows
    do_obs(2'd3, 2'd3);            // applied in THINK cycle 1
    chk("think_obs.err", err, 1'b0);
    @(negedge clk);                // THINK cycle 3
    @(negedge clk);                // THINK cycle 4
    pulse_stop();
    chk("stop_think.busy", busy, 1'b0);
    chk("stop_think.en", enable, 1'b0);
    ens = 0;
    repeat (15) begin
      if (enable) ens++;
      @(negedge clk);
    end
    chk("stop_think.no_en", ens, 0);
    do_start(1'b0, 1'b0);
    chk("restart.err", err, 1'b0);
    chk("restart.busy", busy, 1'b1);
    do_obs(2'd0, 2'd0);
    expect_move("restart", 2'd1, 2'd1, 2'd0);

    // Reset during ISSUE
    do_obs(2'd2, 2'd2);
    wait_enable(n, bok);
    chk("rst_iss.lat", n, 10);
    chk("rst_iss.en", enable, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_iss.en_off", enable, 1'b0);
    chk("rst_iss.pl", player, 2'b11);
    chk("rst_iss.busy", busy, 1'b0);
    chk("rst_iss.x", data_in_x, 2'd0);
    chk("rst_iss.y", data_in_y, 2'd0);
    reset = 1'b0;
    @(negedge clk);
    do_start(1'b1, 1'b1);
    expect_move("post_rst", 2'd1, 2'd1, 2'd1);

    // stop_game during ISSUE: strobe still seen, then DONE
    do_obs(2'd0, 2'd0);
    wait_enable(n, bok);
    chk("stop_iss.lat", n, 10);
    chk("stop_iss.x", data_in_x, 2'd2);
    chk("stop_iss.y", data_in_y, 2'd0);
    pulse_stop();
    chk("stop_iss.busy", busy, 1'b0);
    chk("stop_iss.en_off", enable, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ttt_auto_player.md
TTT_AUTO_PLAYER -- requirements
Module: ttt_auto_player

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: single-cycle pulse that begins a new game.
REQ-004 SHALL have port my_id, input, 1 bit: agent's player number (0 or 1), sampled on an accepted start.
REQ-005 SHALL have port i_first, input, 1 bit: when 1, the agent makes the opening move; sampled on an accepted start.
REQ-006 SHALL have port obs_valid, input, 1 bit: the game engine has accepted an opponent move this cycle.
REQ-007 SHALL have ports obs_x and obs_y, input, 2 bits each: column and row of the opponent move.
REQ-008 SHALL have port stop_game, input, 1 bit: game-over flag from the engine.
REQ-009 SHALL have port enable, output, 1 bit: one-cycle move strobe to the engine.
REQ-010 SHALL have ports data_in_x and data_in_y, output, 2 bits each: column and row of the agent move.
REQ-011 SHALL have port player, output, 2 bits: {1'b0, my_id} during a move, otherwise 3.
REQ-012 SHALL have port busy, output, 1 bit: high in states WAIT_OPP, THINK and ISSUE.
REQ-013 SHALL have port err, output, 1 bit: sticky flag for an illegal observed move.

Function
REQ-014 SHALL keep a 3x3 shadow board, 2 bits per cell: 0 = player 0, 1 = player 1, 3 = empty. Cell index = 3*y + x.
REQ-015 SHALL register all outputs and implement FSM states IDLE, WAIT_OPP, THINK, ISSUE, DONE.
REQ-016 IDLE/DONE + start: clear board to 3, clear err, latch my_id and i_first; go to THINK if i_first = 1, else to WAIT_OPP.
REQ-017 WAIT_OPP + obs_valid with x<3, y<3 and target cell empty: write (1 - my_id) into that cell and go to THINK.
REQ-018 WAIT_OPP + obs_valid with a coordinate of 3 or an occupied cell: set err = 1, leave the board unchanged, stay in WAIT_OPP.
REQ-019 THINK SHALL last exactly 9 cycles and scan idx 0..8, one cell per cycle; each empty cell gets a score: 4 = own mark completes a line, 3 = blocks an opponent line, 2 = centre (idx 4), 1 = corner (idx 0, 2, 6, 8), 0 = other.
REQ-020 A cell SHALL take the highest applicable score; the candidate is the cell with the highest score, and a tie SHALL go to the lowest idx.
REQ-021 After idx 8: go to ISSUE if a candidate exists; otherwise (board full) go to DONE without issuing a move.
REQ-022 ISSUE SHALL last 1 cycle: enable = 1, data_in_x/data_in_y = candidate, player = my_id; write my_id into the shadow cell; then go to WAIT_OPP.
REQ-023 Latency: for an accepted obs_valid or start at cycle t (start only with i_first = 1), enable SHALL be high at cycle t+10 only.
REQ-024 stop_game = 1 in WAIT_OPP, THINK or ISSUE SHALL force DONE on the next edge. If this happens in ISSUE, the strobe that cycle still occurs.
REQ-025 start outside IDLE/DONE SHALL be ignored.
REQ-026 obs_valid outside WAIT_OPP SHALL be ignored and SHALL NOT set err.
REQ-027 Outside ISSUE: enable = 0 and player = 3; data_in_x/data_in_y hold their last values.

Reset
REQ-028 On reset: state IDLE, board all 3, enable 0, data_in_x 0, data_in_y 0, player 3, busy 0, err 0.
REQ-029 Reset SHALL take priority over every other input, including in the middle of THINK or ISSUE.

Verification
REQ-030 Scenario: reset; start, my_id = 0, i_first = 1 -> 10 cycles later: enable = 1, x = 1, y = 1, player = 0; busy = 1 throughout.
REQ-031 Scenario: start, my_id = 1, i_first = 0; obs (1,1) -> enable 10 cycles later with x = 0, y = 0, player = 1.
REQ-032 Scenario: agent (id 0) holds (1,1) and (2,0); opponent holds (0,0); opponent plays (0,1) -> agent plays x = 0, y = 2. Win outranks block at the same cell.
REQ-033 Scenario: obs onto an occupied cell -> err = 1, no enable, state stays WAIT_OPP; a following legal obs still produces a move.
REQ-034 Scenario: stop_game asserted in THINK cycle 4 -> busy = 0 next cycle, enable never asserted; start then restarts the game with err = 0.
REQ-035 Scenario: reset asserted during ISSUE -> enable = 0 and player = 3 on the next edge; a subsequent start gives normal behaviour.
